// File: rtl/snoint_gate_seq.sv
// Gate/hold/convert/dump sequencer for the 4-channel dual-gain charge integrator.
// Latency: ING rises 1 clk after TRIG is sampled; every output is registered.
// Backpressure: waits indefinitely on ADC_ACK per request; TRIG is ignored while busy.
// Optional: SNOINT_GATE_SEQ_LOST_CNT_EN adds LOST_CNT/LOST_CLR (lost-trigger counter).
module snoint_gate_seq #(
  parameter int NCH           = 4,
  parameter int GATE_W        = 8,
  parameter int DUMP_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int ADC_W         = 12
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        TRIG,
  input  logic [GATE_W-1:0]           GATE_LEN,
  input  logic [NCH-1:0]              CH_MASK,
  output logic [NCH-1:0]              ING,
  output logic                        HOLD,
  output logic                        DUMP,
  output logic                        ADC_REQ,
  output logic [$clog2(2*NCH)-1:0]    ADC_SEL,
  input  logic                        ADC_ACK,
  input  logic [ADC_W-1:0]            ADC_DATA,
  output logic                        RESULT_VALID,
  output logic [$clog2(2*NCH)-1:0]    RESULT_SEL,
  output logic [ADC_W-1:0]            RESULT_DATA,
  output logic                        BUSY,
  output logic                        DONE
`ifdef SNOINT_GATE_SEQ_LOST_CNT_EN
  ,
  output logic [7:0]                  LOST_CNT,
  input  logic                        LOST_CLR
`endif
);

  localparam int NS    = 2 * NCH;
  localparam int SEL_W = $clog2(NS);
  localparam int DW    = $clog2(DUMP_CYCLES + 1);
  localparam int SW    = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W = (GATE_W > DW) ? ((GATE_W > SW) ? GATE_W : SW) : ((DW > SW) ? DW : SW);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DUMP_LAST   = CNT_W'(DUMP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_INTEG, S_SETTLE, S_CONVERT, S_DUMP} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n, gate_last;
  logic [GATE_W-1:0]   gate_q, gate_n;
  logic [NCH-1:0]      mask_q, mask_n;
  logic [SEL_W-1:0]    sel_n, rsel_n;
  logic [ADC_W-1:0]    rdata_n;
  logic                req_n, rv_n, done_n, accept;
  logic [NS-1:0]       sel_en, above;
  logic [SEL_W:0]      first_hit, next_hit;

  // Lowest set bit of v as {found, index}.
  function automatic logic [SEL_W:0] lowest(input logic [NS-1:0] v);
    logic [SEL_W:0] r;
    logic [NS-1:0]  t;
    r = '0;
    t = v;
    for (int i = 0; i < NS; i++) begin
      if (t[0] && !r[SEL_W]) r = {1'b1, SEL_W'(i)};
      t = t >> 1;
    end
    return r;
  endfunction

  // Both gains of a channel share its mask bit.
  for (genvar c = 0; c < NCH; c++) begin : g_en
    assign sel_en[2*c+1:2*c] = {2{mask_q[c]}};
  end

  assign above     = ~((NS'(2) << ADC_SEL) - NS'(1));
  assign first_hit = lowest(sel_en);
  assign next_hit  = lowest(sel_en & above);
  assign gate_last = CNT_W'(gate_q) - CNT_W'(1);
  // DONE marks the cycle in which a trigger must not be accepted.
  assign accept    = (state == S_IDLE) && TRIG && !DONE;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gate_n  = gate_q;
    mask_n  = mask_q;
    sel_n   = ADC_SEL;
    req_n   = ADC_REQ;
    rv_n    = 1'b0;
    rsel_n  = RESULT_SEL;
    rdata_n = RESULT_DATA;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          gate_n  = (GATE_LEN == '0) ? GATE_W'(1) : GATE_LEN;
          mask_n  = CH_MASK;
          cnt_n   = '0;
          state_n = S_INTEG;
        end
      end
      S_INTEG: begin
        if (cnt == gate_last) begin
          cnt_n   = '0;
          state_n = S_SETTLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_n = '0;
          if (first_hit[SEL_W]) begin
            sel_n   = first_hit[SEL_W-1:0];
            req_n   = 1'b1;
            state_n = S_CONVERT;
          end else begin
            state_n = S_DUMP;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_CONVERT: begin
        if (!ADC_REQ) begin
          // One idle cycle has passed since the last acknowledge.
          req_n = 1'b1;
        end else if (ADC_ACK) begin
          req_n   = 1'b0;
          rv_n    = 1'b1;
          rsel_n  = ADC_SEL;
          rdata_n = ADC_DATA;
          if (next_hit[SEL_W]) begin
            sel_n = next_hit[SEL_W-1:0];
          end else begin
            sel_n   = '0;
            cnt_n   = '0;
            state_n = S_DUMP;
          end
        end
      end
      S_DUMP: begin
        if (cnt == DUMP_LAST) begin
          cnt_n   = '0;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= S_IDLE;
      cnt          <= '0;
      gate_q       <= '0;
      mask_q       <= '0;
      ADC_SEL      <= '0;
      ADC_REQ      <= 1'b0;
      RESULT_VALID <= 1'b0;
      RESULT_SEL   <= '0;
      RESULT_DATA  <= '0;
      DONE         <= 1'b0;
      ING          <= '0;
      HOLD         <= 1'b0;
      DUMP         <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      gate_q       <= gate_n;
      mask_q       <= mask_n;
      ADC_SEL      <= sel_n;
      ADC_REQ      <= req_n;
      RESULT_VALID <= rv_n;
      RESULT_SEL   <= rsel_n;
      RESULT_DATA  <= rdata_n;
      DONE         <= done_n;
      ING          <= {NCH{state_n == S_INTEG}};
      HOLD         <= (state_n == S_SETTLE) || (state_n == S_CONVERT);
      DUMP         <= (state_n == S_DUMP);
      BUSY         <= (state_n != S_IDLE);
    end
  end

`ifdef SNOINT_GATE_SEQ_LOST_CNT_EN
  logic trig_q;

  // Count TRIG rising edges that arrive while a sequence is running.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      trig_q   <= 1'b0;
      LOST_CNT <= '0;
    end else begin
      trig_q <= TRIG;
      if (LOST_CLR || accept) begin
        LOST_CNT <= '0;
      end else if (TRIG && !trig_q && BUSY && (LOST_CNT != 8'hFF)) begin
        LOST_CNT <= LOST_CNT + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_snoint_gate_seq.sv
// Bench for snoint_gate_seq: table vectors, hand-written corner sequences, random sequences.
// Outputs are sampled and inputs driven on the falling clock edge.
// The ADC side is emulated with random acknowledge delays and random stray acknowledges.
module tb_snoint_gate_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig;
  logic [7:0]  gate_len;
  logic [3:0]  ch_mask;
  logic [3:0]  ing;
  logic        hold, dump, adc_req, adc_ack, result_valid, busy, done;
  logic [2:0]  adc_sel, result_sel;
  logic [11:0] adc_data, result_data;
`ifdef SNOINT_GATE_SEQ_LOST_CNT_EN
  logic [7:0]  lost_cnt;
  logic        lost_clr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snoint_gate_seq dut (
    .CLK(clk), .RST_N(rst_n), .TRIG(trig), .GATE_LEN(gate_len), .CH_MASK(ch_mask),
    .ING(ing), .HOLD(hold), .DUMP(dump), .ADC_REQ(adc_req), .ADC_SEL(adc_sel),
    .ADC_ACK(adc_ack), .ADC_DATA(adc_data), .RESULT_VALID(result_valid),
    .RESULT_SEL(result_sel), .RESULT_DATA(result_data), .BUSY(busy), .DONE(done)
`ifdef SNOINT_GATE_SEQ_LOST_CNT_EN
    , .LOST_CNT(lost_cnt), .LOST_CLR(lost_clr)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for the DONE strobe with the ADC side quiet.
  task automatic wait_done(input string tag, input int budget);
    int cyc;
    cyc = 0;
    adc_ack = 1'b0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  // One full sequence, checked against rules derived from gate length and mask.
  task automatic run_seq(input string tag, input int gate, input logic [3:0] mask,
                         input bit fixed_data, input int exp_ing, input int exp_nreq);
    int ing_c, hold_pre, dump_c, done_c, cyc, sel_bad, busy_bad, overlap, ing_bad, wcnt, wdel;
    bit seen_req, done_seen, req_prev;
    int req_q[$];
    int rs_q[$];
    int rd_q[$];
    int exp_q[$];
    logic [11:0] sent [8];
    logic [2:0] cur_sel;
    ing_c = 0; hold_pre = 0; dump_c = 0; done_c = 0; cyc = 0; sel_bad = 0;
    busy_bad = 0; overlap = 0; ing_bad = 0; wcnt = 0; wdel = 1;
    seen_req = 1'b0; done_seen = 1'b0; req_prev = 1'b0; cur_sel = '0;
    for (int i = 0; i < 8; i++) sent[i] = '0;
    // Expected visiting order: both gains of each enabled channel, channels ascending.
    for (int c = 0; c < 4; c++) begin
      if (mask[c]) begin
        exp_q.push_back(2 * c);
        exp_q.push_back(2 * c + 1);
      end
    end
    @(negedge clk);
    gate_len = 8'(gate);
    ch_mask  = mask;
    trig     = 1'b1;
    adc_ack  = 1'b0;
    @(negedge clk);
    trig = 1'b0;
    check({tag, "_ing_first"}, 32'(ing), 32'hF);
    while (!done_seen && cyc < 3000) begin
      if (ing == 4'hF) ing_c++;
      else if (ing != 4'h0) ing_bad++;
      if (hold && !seen_req && !adc_req) hold_pre++;
      if (hold && ing != 4'h0) overlap++;
      if (adc_req && !req_prev) begin
        req_q.push_back(int'(adc_sel));
        cur_sel  = adc_sel;
        seen_req = 1'b1;
        wdel     = fixed_data ? 3 : int'($urandom_range(1, 4));
        wcnt     = 0;
      end
      if (adc_req && req_prev && adc_sel != cur_sel) sel_bad++;
      if (result_valid) begin
        rs_q.push_back(int'(result_sel));
        rd_q.push_back(int'(result_data));
      end
      if (dump) dump_c++;
      if (done) begin
        done_c++;
        done_seen = 1'b1;
        if (busy) busy_bad++;
      end else if (!busy) begin
        busy_bad++;
      end
      if (adc_req) begin
        wcnt++;
        if (wcnt >= wdel) begin
          adc_ack  = 1'b1;
          adc_data = fixed_data ? (12'h100 + 12'(adc_sel)) : 12'($urandom);
          sent[adc_sel] = adc_data;
        end else begin
          adc_ack  = 1'b0;
          adc_data = 12'($urandom);
        end
      end else begin
        adc_ack  = 1'($urandom_range(0, 1));
        adc_data = 12'($urandom);
      end
      req_prev = adc_req;
      @(negedge clk);
      cyc++;
    end
    adc_ack = 1'b0;
    check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    check({tag, "_ing_len"}, 32'(ing_c), 32'(exp_ing));
    check({tag, "_ing_partial"}, 32'(ing_bad), 32'd0);
    check({tag, "_hold_before_req"}, 32'(hold_pre), 32'd2);
    check({tag, "_hold_ing_overlap"}, 32'(overlap), 32'd0);
    check({tag, "_nreq"}, 32'(req_q.size()), 32'(exp_nreq));
    check({tag, "_nreq_model"}, 32'(req_q.size()), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < req_q.size(); j++)
      check($sformatf("%s_req_sel%0d", tag, j), 32'(req_q[j]), 32'(exp_q[j]));
    check({tag, "_sel_unstable"}, 32'(sel_bad), 32'd0);
    check({tag, "_nresult"}, 32'(rs_q.size()), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < rs_q.size(); j++) begin
      check($sformatf("%s_res_sel%0d", tag, j), 32'(rs_q[j]), 32'(exp_q[j]));
      if (fixed_data)
        check($sformatf("%s_res_dat%0d", tag, j), 32'(rd_q[j]), 32'h100 + 32'(exp_q[j]));
      else
        check($sformatf("%s_res_dat%0d", tag, j), 32'(rd_q[j]), 32'(sent[exp_q[j]]));
    end
    check({tag, "_dump_len"}, 32'(dump_c), 32'd16);
    check({tag, "_done_cnt"}, 32'(done_c), 32'd1);
    check({tag, "_busy_pattern"}, 32'(busy_bad), 32'd0);
    @(negedge clk);
    check({tag, "_done_width"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    int         gate;
    logic [3:0] mask;
    bit         fixed;
    int         exp_ing;
    int         exp_nreq;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int   cyc;
    tbl[0] = '{5,   4'b1111, 1'b1, 5,   8};
    tbl[1] = '{5,   4'b0101, 1'b1, 5,   4};
    tbl[2] = '{0,   4'b0000, 1'b1, 1,   0};
    tbl[3] = '{1,   4'b1000, 1'b0, 1,   2};
    tbl[4] = '{255, 4'b0010, 1'b0, 255, 2};

    rst_n = 1'b0; trig = 1'b1; gate_len = 8'd3; ch_mask = 4'h0;
    adc_ack = 1'b0; adc_data = '0;
`ifdef SNOINT_GATE_SEQ_LOST_CNT_EN
    lost_clr = 1'b0;
`endif

    // Reset held with TRIG high: everything quiet.
    repeat (3) @(negedge clk);
    check("rst_outputs", {8'b0, ing, hold, dump, adc_req, adc_sel, result_valid, result_sel,
                          result_data, busy, done}, 32'd0);
    check("rst_ing", 32'(ing), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ing", 32'(ing), 32'hF);
    check("rst_release_busy", 32'(busy), 32'd1);
    trig = 1'b0;
    wait_done("rst_drain", 200);
    @(negedge clk);

    // Table-driven vectors.
    for (int v = 0; v < 5; v++)
      run_seq($sformatf("tbl%0d", v), tbl[v].gate, tbl[v].mask, tbl[v].fixed,
              tbl[v].exp_ing, tbl[v].exp_nreq);

    // TRIG held high in the DONE cycle is not accepted; the next edge is.
    gate_len = 8'd1; ch_mask = 4'h0; trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_done("donecyc", 200);
    trig = 1'b1;
    @(negedge clk);
    check("donecyc_not_taken_ing", 32'(ing), 32'd0);
    check("donecyc_not_taken_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("donecyc_next_taken", 32'(ing), 32'hF);
    trig = 1'b0;
    wait_done("donecyc_drain", 200);
    @(negedge clk);

    // Async reset while a request is outstanding.
    gate_len = 8'd2; ch_mask = 4'hF; trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    cyc = 0;
    while (!adc_req && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("arst_req_seen", 32'(adc_req), 32'd1);
    #2;
    rst_n = 1'b0;
    adc_ack = 1'b1;
    #1;
    check("arst_req_drop", 32'(adc_req), 32'd0);
    check("arst_hold_drop", 32'(hold), 32'd0);
    check("arst_busy_drop", 32'(busy), 32'd0);
    check("arst_dump_none", 32'(dump), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    adc_ack = 1'b0;
    @(negedge clk);
    check("arst_stay_idle", 32'(busy), 32'd0);
    run_seq("after_arst", 3, 4'b1111, 1'b1, 3, 8);

    // Randomized sequences checked against the mask/gate rules.
    for (int r = 0; r < 15; r++) begin
      int         g;
      logic [3:0] m;
      g = int'($urandom_range(0, 12));
      m = 4'($urandom_range(0, 15));
      run_seq($sformatf("rnd%0d", r), g, m, 1'b0, (g == 0) ? 1 : g, 2 * $countones(m));
    end

`ifdef SNOINT_GATE_SEQ_LOST_CNT_EN
    // Lost-trigger counter; the ADC never acknowledges, so the block stays busy.
    gate_len = 8'd4; ch_mask = 4'hF; adc_ack = 1'b0; trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    @(negedge clk);
    check("lost_after_accept", 32'(lost_cnt), 32'd0);
    repeat (3) begin
      @(negedge clk); trig = 1'b1;
      @(negedge clk); trig = 1'b0;
    end
    @(negedge clk);
    check("lost_three", 32'(lost_cnt), 32'd3);
    repeat (300) begin
      @(negedge clk); trig = 1'b1;
      @(negedge clk); trig = 1'b0;
    end
    @(negedge clk);
    check("lost_saturate", 32'(lost_cnt), 32'd255);
    check("lost_still_busy", 32'(busy), 32'd1);
    check("lost_still_req", 32'(adc_req), 32'd1);
    trig = 1'b1; lost_clr = 1'b1;
    @(negedge clk);
    trig = 1'b0; lost_clr = 1'b0;
    @(negedge clk);
    check("lost_clr_wins", 32'(lost_cnt), 32'd0);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    @(negedge clk);
    check("lost_count_again", 32'(lost_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check("lost_reset", 32'(lost_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snoint_gate_seq.md
Name: snoint_gate_seq

Overview:
- Digital sequencer that drives the 4-channel dual-gain charge integrator from the controlling end.
- Opens the integration gates on a trigger, holds the integrated charge, then reads each enabled channel's high- and low-gain charge through an ADC request/acknowledge handshake.
- Finally pulses the integrator dump (discharge) and returns to idle.
- Sits on the FEC32 digital side between trigger logic and the channel ADC.

Parameters:
- NCH, 4, number of integrator channels (each has H and L gain outputs).
- GATE_W, 8, width of the GATE_LEN programmable gate-length input.
- DUMP_CYCLES, 16, number of clocks DUMP is held high (min 1).
- SETTLE_CYCLES, 2, clocks between gate close and first ADC request (min 1).
- ADC_W, 12, ADC result width.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- TRIG  in  1  integration trigger, level-sampled.
- GATE_LEN  in  GATE_W  integration gate length in clocks; 0 is treated as 1.
- CH_MASK  in  NCH  channel read-out enable, bit i = channel i+1.
- ING  out  NCH  per-channel integrate gate, high = integrating.
- HOLD  out  1  integrator hold for readout.
- DUMP  out  1  integrator discharge.
- ADC_REQ  out  1  conversion request.
- ADC_SEL  out  $clog2(2*NCH)  conversion select = 2*ch + gain (gain 0 = H, 1 = L).
- ADC_ACK  in  1  conversion complete.
- ADC_DATA  in  ADC_W  conversion result, valid when ADC_ACK is high.
- RESULT_VALID  out  1  one-cycle strobe per captured result.
- RESULT_SEL  out  $clog2(2*NCH)  select of the captured result.
- RESULT_DATA  out  ADC_W  captured result.
- BUSY  out  1  high whenever the state is not IDLE.
- DONE  out  1  one-cycle pulse at the end of a sequence.

Behaviour:
- Reset (async, active-low): state IDLE. All outputs 0: ING, HOLD, DUMP, ADC_REQ, ADC_SEL, RESULT_*, BUSY, DONE. All counters and latched registers also clear.
- Reset asserted mid-sequence: outputs drop immediately with no dump pulse. Any in-flight ADC_ACK is ignored.
- Registered outputs only. State machine: IDLE -> INTEG -> SETTLE -> CONVERT -> DUMP -> IDLE.
- IDLE:
  - TRIG is sampled high at edge k -> latch GATE_LEN (0 becomes 1) and CH_MASK, then enter INTEG.
  - From cycle k+1: ING = all ones, BUSY = 1.
  - TRIG is ignored in every other state; no queuing.
- INTEG:
  - ING stays high for exactly the latched GATE_LEN cycles.
  - Then ING = 0 and HOLD = 1 in the same cycle, and the state goes to SETTLE.
- SETTLE:
  - Lasts SETTLE_CYCLES clocks, HOLD = 1.
  - Exit to CONVERT if the latched mask is non-zero, otherwise to DUMP.
- CONVERT:
  - Visit selects in ascending order 0..2*NCH-1, skipping both selects of any masked-off channel.
  - For each select: drive ADC_SEL and assert ADC_REQ; keep both stable until ADC_ACK is sampled high.
  - On that edge: capture ADC_DATA into RESULT_DATA and ADC_SEL into RESULT_SEL, pulse RESULT_VALID next cycle, and drop ADC_REQ.
  - ADC_REQ stays low at least one cycle before the next request.
  - ADC_ACK while ADC_REQ is low is ignored.
  - No timeout: the block waits indefinitely.
  - After the last enabled select is acknowledged, go to DUMP.
- DUMP:
  - HOLD = 0, DUMP = 1 for DUMP_CYCLES clocks.
  - Then DUMP = 0, DONE pulses for 1 cycle, state goes to IDLE, BUSY = 0.
- A TRIG high in the DONE cycle is not accepted. The first acceptable edge is the following one.

Optional Feature:
- Macro: SNOINT_GATE_SEQ_LOST_CNT_EN.
- Defined:
  - Adds output LOST_CNT [7:0]. It counts cycles where TRIG rises (0->1 vs. previous-cycle TRIG) while BUSY = 1.
  - Saturates at 255, clears on reset, and clears on any accepted trigger in IDLE.
  - Adds input LOST_CLR; a 1-cycle pulse clears it. If LOST_CLR and an increment coincide, the clear wins.
- Undefined: no LOST_CNT port, no LOST_CLR port, no counter logic.

Test Plan:
- Reset check: hold RST_N = 0 with TRIG = 1 -> all outputs 0. Release RST_N -> ING goes high 1 cycle after the first sampled TRIG.
- GATE_LEN = 5, CH_MASK = 4'b1111, ADC_ACK returned 3 cycles after each REQ with data 12'h100+sel:
  - ING high exactly 5 cycles, HOLD high 2 cycles before the first REQ.
  - 8 RESULT_VALID strobes with RESULT_SEL 0..7 and data 12'h100..12'h107.
  - DUMP high 16 cycles, then one DONE pulse.
- CH_MASK = 4'b0101 -> requests only for selects 0, 1, 4, 5, in that order. ADC_SEL stays stable while REQ is high.
- CH_MASK = 0, GATE_LEN = 0 -> ING high 1 cycle, 2 SETTLE cycles, then DUMP. No ADC_REQ ever.
- Async reset pulsed during CONVERT with REQ high -> REQ, HOLD and BUSY drop without waiting for a clock. Next TRIG restarts at select 0.
- With SNOINT_GATE_SEQ_LOST_CNT_EN defined:
  - 3 TRIG rising edges while BUSY -> LOST_CNT = 3.
  - 300 rising edges -> LOST_CNT = 255.
  - LOST_CLR pulse -> LOST_CNT = 0.
